// File: rtl/fminmax_pipe_if.sv
// Operand/result handshake bundle for fminmax_pipe.
// master = producer/consumer side, slave = the min/max unit.
interface fminmax_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in1;
    logic [W-1:0]     in2;
    logic             op_max;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [TAG_W-1:0] out_tag;
    logic             invalid;
    logic             nv_sticky;
    logic             nv_clr;

    modport master (
        output in_valid, in1, in2, op_max, in_tag, out_ready, nv_clr,
        input  in_ready, out_valid, result, out_tag, invalid, nv_sticky
    );

    modport slave (
        input  in_valid, in1, in2, op_max, in_tag, out_ready, nv_clr,
        output in_ready, out_valid, result, out_tag, invalid, nv_sticky
    );
endinterface

// File: rtl/fminmax_pipe.sv
// Two-stage IEEE-754 FMIN/FMAX with valid/ready flow control and sticky NV flag.
// S1 holds operand classes plus the sign-magnitude compare; S2 holds the selected result.
module fminmax_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5
) (
    input  logic          CLK,
    input  logic          RST,
    fminmax_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic f_is_nan(input logic [W-1:0] v);
        return (&v[W-2:MAN_W]) & (|v[MAN_W-1:0]);
    endfunction

    function automatic logic f_is_snan(input logic [W-1:0] v);
        return f_is_nan(v) & ~v[MAN_W-1];
    endfunction

    // -0 sorts below +0 because differing signs are decided by sign alone.
    function automatic logic f_lt(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a[W-1] != b[W-1]) ? a[W-1] :
               (a[W-1] ? (a[W-2:0] > b[W-2:0]) : (a[W-2:0] < b[W-2:0]));
    endfunction

    logic             r_s1_valid;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic             r_s1_op_max;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_a_nan;
    logic             r_s1_b_nan;
    logic             r_s1_a_snan;
    logic             r_s1_b_snan;
    logic             r_s1_a_lt_b;

    logic             r_s2_valid;
    logic [W-1:0]     r_s2_result;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_invalid;
    logic             r_nv_sticky;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [W-1:0]     w_sel;
    logic             w_inv;
    logic             w_nv_set;

    assign w_s2_load = ~r_s2_valid | bus.out_ready;
    assign w_s1_load = ~r_s1_valid | w_s2_load;
    assign w_nv_set  = r_s2_valid & bus.out_ready & r_s2_invalid;

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.result    = r_s2_result;
    assign bus.out_tag   = r_s2_tag;
    assign bus.invalid   = r_s2_invalid;
    assign bus.nv_sticky = r_nv_sticky;

    // Stage 1: classify operands and resolve their ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= {W{1'b0}};
            r_s1_b      <= {W{1'b0}};
            r_s1_op_max <= 1'b0;
            r_s1_tag    <= {TAG_W{1'b0}};
            r_s1_a_nan  <= 1'b0;
            r_s1_b_nan  <= 1'b0;
            r_s1_a_snan <= 1'b0;
            r_s1_b_snan <= 1'b0;
            r_s1_a_lt_b <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a      <= bus.in1;
                r_s1_b      <= bus.in2;
                r_s1_op_max <= bus.op_max;
                r_s1_tag    <= bus.in_tag;
                r_s1_a_nan  <= f_is_nan(bus.in1);
                r_s1_b_nan  <= f_is_nan(bus.in2);
                r_s1_a_snan <= f_is_snan(bus.in1);
                r_s1_b_snan <= f_is_snan(bus.in2);
                r_s1_a_lt_b <= f_lt(bus.in1, bus.in2);
            end
        end
    end

    // Result selection; operand a wins when op_max disagrees with a<b.
    always_comb begin
        w_sel = r_s1_b;
        w_inv = r_s1_a_snan | r_s1_b_snan;
        case ({r_s1_a_nan, r_s1_b_nan})
            2'b11:   w_sel = QNAN;
            2'b10:   w_sel = r_s1_b;
            2'b01:   w_sel = r_s1_a;
            2'b00:   w_sel = (r_s1_op_max ^ r_s1_a_lt_b) ? r_s1_a : r_s1_b;
            default: w_sel = QNAN;
        endcase
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s2_valid   <= 1'b0;
            r_s2_result  <= {W{1'b0}};
            r_s2_tag     <= {TAG_W{1'b0}};
            r_s2_invalid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result  <= w_sel;
                r_s2_tag     <= r_s1_tag;
                r_s2_invalid <= w_inv;
            end
        end
    end

    // Sticky NV: a flagged result leaving the block outranks a clear request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_nv_sticky <= 1'b0;
        end else if (w_nv_set) begin
            r_nv_sticky <= 1'b1;
        end else if (bus.nv_clr) begin
            r_nv_sticky <= 1'b0;
        end
    end
endmodule
